// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
// Anode polarity and the blank code live here so every file agrees.
package sevenseg_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic       ANODE_ON    = 1'b0;
  localparam logic       ANODE_OFF   = 1'b1;
  localparam int         MAX_DIGITS  = 8;

  typedef enum logic {
    PH_BLANK,
    PH_ON
  } phase_e;

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Datapath-side bundle of the scan controller.
// master = value producer / pin owner, slave = scan controller.
interface sevenseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    lz_suppress;
  logic [3:0]              digit_out;
  logic [NUM_DIGITS-1:0]   anodes;
  logic                    frame_tick;

  modport master (
    output enable,
    output load,
    output bcd_in,
    output lz_suppress,
    input  digit_out,
    input  anodes,
    input  frame_tick
  );

  modport slave (
    input  enable,
    input  load,
    input  bcd_in,
    input  lz_suppress,
    output digit_out,
    output anodes,
    output frame_tick
  );

endinterface

// File: rtl/sevenseg_slot_timer.sv
// Slot prescaler plus digit index for the display scan.
// Blank phase is decoded straight from the prescaler count.
module sevenseg_slot_timer
  import sevenseg_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 500,
  localparam int IDX_W        = idx_width(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [IDX_W-1:0] idx,
  output logic             in_blank,
  output logic             frame_wrap
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cnt_last;
  logic             idx_last;

  assign cnt_last = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    frame_wrap = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_last) begin
      cnt_d      = '0;
      idx_d      = idx_last ? '0 : idx_q + 1'b1;
      frame_wrap = idx_last;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // A zero-length dead time must not build an always-false compare
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (cnt_q < CNT_W'(BLANK_CYCLES));
  end

  assign idx = idx_q;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display.
// Shadow register, leading-zero mask and registered anode/digit outputs.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  sevenseg_scan_ctrl_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int DW    = 4 * NUM_DIGITS;

  logic [IDX_W-1:0]      idx;
  logic                  in_blank;
  logic                  frame_wrap;
  phase_e                phase;

  logic [DW-1:0]         shadow_q, shadow_d;
  logic [3:0]            digit_out_q, digit_out_d;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0] sup;
  logic                  zero_run;

  sevenseg_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (bus.enable),
    .idx       (idx),
    .in_blank  (in_blank),
    .frame_wrap(frame_wrap)
  );

  assign phase = in_blank ? PH_BLANK : PH_ON;

  // Zero run scanned from the MSD; digit 0 never joins the mask
  always_comb begin
    zero_run = 1'b1;
    sup      = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (shadow_q[4*i +: 4] == 4'h0);
      sup[i]   = bus.lz_suppress & zero_run;
    end
  end

  always_comb begin
    shadow_d     = bus.load ? bus.bcd_in : shadow_q;
    anodes_d     = {NUM_DIGITS{ANODE_OFF}};
    digit_out_d  = DIGIT_BLANK;
    frame_tick_d = frame_wrap;
    if (bus.enable && phase == PH_ON) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDX_W'(i)) begin
          anodes_d[i] = ANODE_ON;
          digit_out_d = sup[i] ? DIGIT_BLANK
                               : shadow_q[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '0;
      anodes_q     <= {NUM_DIGITS{ANODE_OFF}};
      digit_out_q  <= DIGIT_BLANK;
      frame_tick_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      anodes_q     <= anodes_d;
      digit_out_q  <= digit_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.anodes     = anodes_q;
  assign bus.digit_out  = digit_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
